// File: rtl/axi_reg_bank_if.sv
// AXI4 bus bundle between the interconnect (master) and the register bank (slave).
// Signal suffixes are relative to the slave.
interface axi_reg_bank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   awid_i;
  logic [ADDR_W-1:0] awaddr_i;
  logic              awvalid_i;
  logic              awready_o;

  logic [DATA_W-1:0] wdata_i;
  logic [STRB_W-1:0] wstrb_i;
  logic              wlast_i;
  logic              wvalid_i;
  logic              wready_o;

  logic [ID_W-1:0]   bid_o;
  logic [1:0]        bresp_o;
  logic              bvalid_o;
  logic              bready_i;

  logic [ID_W-1:0]   arid_i;
  logic [ADDR_W-1:0] araddr_i;
  logic              arvalid_i;
  logic              arready_o;

  logic [ID_W-1:0]   rid_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rresp_o;
  logic              rlast_o;
  logic              rvalid_o;
  logic              rready_i;

  modport slave (
    input  awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
           bready_i, arid_i, araddr_i, arvalid_i, rready_i,
    output awready_o, wready_o, bid_o, bresp_o, bvalid_o, arready_o,
           rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport master (
    output awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
           bready_i, arid_i, araddr_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bid_o, bresp_o, bvalid_o, arready_o,
           rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/axi_reg_bank.sv
// AXI slave register bank: byte-strobed single-beat writes, single-beat reads,
// SLVERR on out-of-range or multi-beat writes; contents exported flat on regs_o.
module axi_reg_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                       clk,
  input  logic                       areset,
  axi_reg_bank_if.slave              s_axi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BL     = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned HA_W   = ADDR_W - BL;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  logic              aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [ID_W-1:0]   awid_h_q, awid_h_d;
  logic [HA_W-1:0]   awaddr_h_q, awaddr_h_d;
  logic [DATA_W-1:0] wdata_h_q, wdata_h_d;
  logic [STRB_W-1:0] wstrb_h_q, wstrb_h_d;
  logic              wlast_h_q, wlast_h_d;

  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_in_range, rd_in_range;

  // Byte-lane offset bits never select anything.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi.awaddr_i[BL-1:0], s_axi.araddr_i[BL-1:0]};

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      regs_q     <= '0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      awid_h_q   <= '0;
      awaddr_h_q <= '0;
      wdata_h_q  <= '0;
      wstrb_h_q  <= '0;
      wlast_h_q  <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      regs_q     <= regs_d;
      aw_have_q  <= aw_have_d;
      w_have_q   <= w_have_d;
      awid_h_q   <= awid_h_d;
      awaddr_h_q <= awaddr_h_d;
      wdata_h_q  <= wdata_h_d;
      wstrb_h_q  <= wstrb_h_d;
      wlast_h_q  <= wlast_h_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Write path: AW and W captured independently, commit once both are held.
  always_comb begin
    w_state_d   = w_state_q;
    regs_d      = regs_q;
    aw_have_d   = aw_have_q;
    w_have_d    = w_have_q;
    awid_h_d    = awid_h_q;
    awaddr_h_d  = awaddr_h_q;
    wdata_h_d   = wdata_h_q;
    wstrb_h_d   = wstrb_h_q;
    wlast_h_d   = wlast_h_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    wr_idx      = '0;
    wr_in_range = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid_i && awready_q) begin
          aw_have_d  = 1'b1;
          awid_h_d   = s_axi.awid_i;
          awaddr_h_d = s_axi.awaddr_i[ADDR_W-1:BL];
        end
        if (s_axi.wvalid_i && wready_q) begin
          w_have_d  = 1'b1;
          wdata_h_d = s_axi.wdata_i;
          wstrb_h_d = s_axi.wstrb_i;
          wlast_h_d = s_axi.wlast_i;
        end
        if (aw_have_d && w_have_d) begin
          wr_idx      = awaddr_h_d[IDX_W-1:0];
          wr_in_range = (awaddr_h_d[HA_W-1:IDX_W] == '0);
          if (wr_in_range && wlast_h_d) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
              if (wstrb_h_d[i]) regs_d[wr_idx][i*8 +: 8] = wdata_h_d[i*8 +: 8];
            end
            bresp_d = OKAY;
          end else begin
            bresp_d = SLVERR;
          end
          bid_d     = awid_h_d;
          bvalid_d  = 1'b1;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.bready_i) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // Readies reopen one cycle after returning to idle.
    awready_d = (w_state_q == W_IDLE) && (w_state_d == W_IDLE) && !aw_have_d;
    wready_d  = (w_state_q == W_IDLE) && (w_state_d == W_IDLE) && !w_have_d;
  end

  // Read path: samples pre-commit register contents.
  always_comb begin
    r_state_d   = r_state_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_idx      = s_axi.araddr_i[BL +: IDX_W];
    rd_in_range = (s_axi.araddr_i[ADDR_W-1:BL+IDX_W] == '0);
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid_i && arready_q) begin
          rid_d = s_axi.arid_i;
          if (rd_in_range) begin
            rdata_d = regs_q[rd_idx];
            rresp_d = OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = SLVERR;
          end
          rvalid_d  = 1'b1;
          rlast_d   = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready_i) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  assign s_axi.awready_o = awready_q;
  assign s_axi.wready_o  = wready_q;
  assign s_axi.bvalid_o  = bvalid_q;
  assign s_axi.bid_o     = bid_q;
  assign s_axi.bresp_o   = bresp_q;
  assign s_axi.arready_o = arready_q;
  assign s_axi.rvalid_o  = rvalid_q;
  assign s_axi.rlast_o   = rlast_q;
  assign s_axi.rid_o     = rid_q;
  assign s_axi.rdata_o   = rdata_q;
  assign s_axi.rresp_o   = rresp_q;
  assign regs_o          = regs_q;
endmodule

// File: tb/tb_axi_reg_bank.sv
// Directed self-checking bench for axi_reg_bank (DATA_W=32, NUM_REGS=8).
module tb_axi_reg_bank;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned RW       = NUM_REGS * DATA_W;

  logic          clk = 1'b0;
  logic          areset;
  logic [RW-1:0] regs_o;
  logic [RW-1:0] exp_regs;
  int            checks   = 0;
  int            failures = 0;

  logic [1:0]        resp;
  logic [ID_W-1:0]   id;
  logic [DATA_W-1:0] data;

  axi_reg_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  axi_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .NUM_REGS(NUM_REGS)) dut (
    .clk    (clk),
    .areset (areset),
    .s_axi  (bus),
    .regs_o (regs_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    checks++;
    assert (regs_o === exp_regs) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, regs_o, exp_regs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input bit want_w, input bit want_r);
    int  n = 0;
    logic ok;
    ok = (!want_w || (bus.awready_o && bus.wready_o)) && (!want_r || bus.arready_o);
    while (!ok && n < 10) begin
      tick();
      n++;
      ok = (!want_w || (bus.awready_o && bus.wready_o)) && (!want_r || bus.arready_o);
    end
    chk({tag, "_ready_timeout"}, 64'(ok), 64'h1);
  endtask

  task automatic do_write(input string tag, input logic [ID_W-1:0] wid, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, input logic [3:0] strb, input logic last,
                          output logic [1:0] bresp, output logic [ID_W-1:0] bid);
    wait_ready(tag, 1'b1, 1'b0);
    bus.awid_i = wid;  bus.awaddr_i = addr; bus.awvalid_i = 1'b1;
    bus.wdata_i = wd;  bus.wstrb_i = strb;  bus.wlast_i = last; bus.wvalid_i = 1'b1;
    tick();
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    chk({tag, "_bvalid"}, 64'(bus.bvalid_o), 64'h1);
    bresp = bus.bresp_o;
    bid   = bus.bid_o;
    bus.bready_i = 1'b1;
    tick();
    bus.bready_i = 1'b0;
    chk({tag, "_bvalid_drop"}, 64'(bus.bvalid_o), 64'h0);
  endtask

  task automatic do_read(input string tag, input logic [ID_W-1:0] aid, input logic [ADDR_W-1:0] addr,
                         output logic [DATA_W-1:0] rd, output logic [1:0] rresp, output logic [ID_W-1:0] rid);
    wait_ready(tag, 1'b0, 1'b1);
    bus.arid_i = aid; bus.araddr_i = addr; bus.arvalid_i = 1'b1;
    tick();
    bus.arvalid_i = 1'b0;
    chk({tag, "_rvalid"}, 64'(bus.rvalid_o), 64'h1);
    chk({tag, "_rlast"}, 64'(bus.rlast_o), 64'h1);
    rd    = bus.rdata_o;
    rresp = bus.rresp_o;
    rid   = bus.rid_o;
    bus.rready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0;
    chk({tag, "_rvalid_drop"}, 64'(bus.rvalid_o), 64'h0);
  endtask

  initial begin
    areset = 1'b0;
    bus.awid_i = '0; bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
    bus.wdata_i = '0; bus.wstrb_i = '0; bus.wlast_i = 1'b0; bus.wvalid_i = 1'b0;
    bus.bready_i = 1'b0;
    bus.arid_i = '0; bus.araddr_i = '0; bus.arvalid_i = 1'b0;
    bus.rready_i = 1'b0;
    exp_regs = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", 64'(bus.awready_o), 64'h0);
    chk("rst_wready",  64'(bus.wready_o),  64'h0);
    chk("rst_arready", 64'(bus.arready_o), 64'h0);
    chk("rst_bvalid",  64'(bus.bvalid_o),  64'h0);
    chk("rst_rvalid",  64'(bus.rvalid_o),  64'h0);
    chk("rst_rdata",   64'(bus.rdata_o),   64'h0);
    chk_regs("rst_regs");
    areset = 1'b1;
    chk("rel_awready_pre", 64'(bus.awready_o), 64'h0);
    tick();
    chk("rel_awready", 64'(bus.awready_o), 64'h1);
    chk("rel_wready",  64'(bus.wready_o),  64'h1);
    chk("rel_arready", 64'(bus.arready_o), 64'h1);

    // Full-word write then read back
    do_write("wr1", 4'h3, 32'h04, 32'hDEADBEEF, 4'hF, 1'b1, resp, id);
    chk("wr1_bresp", 64'(resp), 64'h0);
    chk("wr1_bid",   64'(id),   64'h3);
    exp_regs[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
    chk_regs("wr1_regs");
    do_read("rd1", 4'h5, 32'h04, data, resp, id);
    chk("rd1_rdata", 64'(data), 64'hDEADBEEF);
    chk("rd1_rresp", 64'(resp), 64'h0);
    chk("rd1_rid",   64'(id),   64'h5);

    // W ahead of AW, partial strobe
    do_write("wr3", 4'h1, 32'h0C, 32'hFFFFFFFF, 4'hF, 1'b1, resp, id);
    exp_regs[3*DATA_W +: DATA_W] = 32'hFFFFFFFF;
    chk_regs("wr3_regs");
    wait_ready("wfirst", 1'b1, 1'b0);
    bus.wdata_i = 32'h11223344; bus.wstrb_i = 4'h5; bus.wlast_i = 1'b1; bus.wvalid_i = 1'b1;
    tick();
    bus.wvalid_i = 1'b0;
    chk("wfirst_wready",  64'(bus.wready_o),  64'h0);
    chk("wfirst_awready", 64'(bus.awready_o), 64'h1);
    chk("wfirst_bvalid",  64'(bus.bvalid_o),  64'h0);
    tick();
    chk_regs("wfirst_no_commit");
    bus.awid_i = 4'h7; bus.awaddr_i = 32'h0C; bus.awvalid_i = 1'b1;
    tick();
    bus.awvalid_i = 1'b0;
    chk("wfirst_bvalid2", 64'(bus.bvalid_o), 64'h1);
    chk("wfirst_bid",     64'(bus.bid_o),    64'h7);
    chk("wfirst_bresp",   64'(bus.bresp_o),  64'h0);
    exp_regs[3*DATA_W +: DATA_W] = 32'hFF22FF44;
    chk_regs("wfirst_regs");
    bus.bready_i = 1'b1;
    tick();
    bus.bready_i = 1'b0;

    // Out of range write and read
    do_write("oor_wr", 4'h2, 32'h20, 32'hA5A5A5A5, 4'hF, 1'b1, resp, id);
    chk("oor_bresp", 64'(resp), 64'h2);
    chk("oor_bid",   64'(id),   64'h2);
    chk_regs("oor_regs");
    do_read("oor_rd", 4'h4, 32'h20, data, resp, id);
    chk("oor_rdata", 64'(data), 64'h0);
    chk("oor_rresp", 64'(resp), 64'h2);
    chk("oor_rid",   64'(id),   64'h4);

    // Multi-beat write is rejected
    do_write("nolast", 4'h6, 32'h08, 32'h77777777, 4'hF, 1'b0, resp, id);
    chk("nolast_bresp", 64'(resp), 64'h2);
    chk_regs("nolast_regs");

    // B channel back-pressure
    wait_ready("bstall", 1'b1, 1'b0);
    bus.awid_i = 4'h9; bus.awaddr_i = 32'h10; bus.awvalid_i = 1'b1;
    bus.wdata_i = 32'h12345678; bus.wstrb_i = 4'hF; bus.wlast_i = 1'b1; bus.wvalid_i = 1'b1;
    tick();
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bstall_bvalid",  64'(bus.bvalid_o),  64'h1);
      chk("bstall_bid",     64'(bus.bid_o),     64'h9);
      chk("bstall_bresp",   64'(bus.bresp_o),   64'h0);
      chk("bstall_awready", 64'(bus.awready_o), 64'h0);
      chk("bstall_wready",  64'(bus.wready_o),  64'h0);
      tick();
    end
    bus.bready_i = 1'b1;
    tick();
    bus.bready_i = 1'b0;
    chk("bstall_release", 64'(bus.bvalid_o), 64'h0);
    exp_regs[4*DATA_W +: DATA_W] = 32'h12345678;
    chk_regs("bstall_regs");

    // R channel back-pressure
    wait_ready("rstall", 1'b0, 1'b1);
    bus.arid_i = 4'h6; bus.araddr_i = 32'h10; bus.arvalid_i = 1'b1;
    tick();
    bus.arvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rstall_rvalid",  64'(bus.rvalid_o),  64'h1);
      chk("rstall_rid",     64'(bus.rid_o),     64'h6);
      chk("rstall_rdata",   64'(bus.rdata_o),   64'h12345678);
      chk("rstall_arready", 64'(bus.arready_o), 64'h0);
      tick();
    end
    bus.rready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0;
    chk("rstall_release", 64'(bus.rvalid_o), 64'h0);

    // Read racing a write commit to the same register
    do_write("race_pre", 4'h0, 32'h08, 32'h00000001, 4'hF, 1'b1, resp, id);
    exp_regs[2*DATA_W +: DATA_W] = 32'h00000001;
    chk_regs("race_pre_regs");
    wait_ready("race", 1'b1, 1'b1);
    bus.awid_i = 4'h8; bus.awaddr_i = 32'h08; bus.awvalid_i = 1'b1;
    bus.wdata_i = 32'h00000005; bus.wstrb_i = 4'hF; bus.wlast_i = 1'b1; bus.wvalid_i = 1'b1;
    bus.arid_i = 4'h1; bus.araddr_i = 32'h08; bus.arvalid_i = 1'b1;
    tick();
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
    chk("race_rvalid", 64'(bus.rvalid_o), 64'h1);
    chk("race_rdata",  64'(bus.rdata_o),  64'h1);
    chk("race_bvalid", 64'(bus.bvalid_o), 64'h1);
    exp_regs[2*DATA_W +: DATA_W] = 32'h00000005;
    chk_regs("race_regs");
    bus.bready_i = 1'b1; bus.rready_i = 1'b1;
    tick();
    bus.bready_i = 1'b0; bus.rready_i = 1'b0;
    do_read("race_after", 4'h2, 32'h08, data, resp, id);
    chk("race_after_rdata", 64'(data), 64'h5);

    // Reset asserted while a response is pending
    wait_ready("rstmid", 1'b1, 1'b0);
    bus.awid_i = 4'hA; bus.awaddr_i = 32'h00; bus.awvalid_i = 1'b1;
    bus.wdata_i = 32'hCAFEF00D; bus.wstrb_i = 4'hF; bus.wlast_i = 1'b1; bus.wvalid_i = 1'b1;
    tick();
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    chk("rstmid_bvalid", 64'(bus.bvalid_o), 64'h1);
    exp_regs[0 +: DATA_W] = 32'hCAFEF00D;
    chk_regs("rstmid_commit");
    #2 areset = 1'b0;
    #1;
    exp_regs = '0;
    chk("rstmid_bvalid_drop", 64'(bus.bvalid_o),  64'h0);
    chk("rstmid_awready",     64'(bus.awready_o), 64'h0);
    chk_regs("rstmid_regs");
    tick();
    areset = 1'b1;
    tick();
    chk("rstmid_awready_back", 64'(bus.awready_o), 64'h1);
    chk("rstmid_no_resp",      64'(bus.bvalid_o),  64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
